// File: rtl/rf_scb.sv
// rf_scb: register file (2R/1W) with per-register busy scoreboard and post-reset clear engine.
// Latency: reads combinational, writes/busy updates at next edge; `RF_BYPASS_EN forwards wr_* to reads.
// Backpressure: none; wr_en/iss_en are ignored until init_done rises (NUM_REGS edges after reset).
module rf_scb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [NUM_REGS-1:0] busy;
  logic [DATA_W-1:0]   mem [NUM_REGS];

  logic run;
  logic wr_ok;
  logic iss_ok;
  logic rs1_ok;
  logic rs2_ok;

  // An address is usable when it exists in the array and is not the hardwired zero register.
  function automatic logic addr_usable(input logic [ADDR_W-1:0] a);
    logic in_range;
    in_range = ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS));
    return in_range && !(ZERO_REG && (a == '0));
  endfunction

  assign run    = (state == RUN);
  assign wr_ok  = run && wr_en  && addr_usable(wr_addr);
  assign iss_ok = run && iss_en && addr_usable(iss_rd);
  assign rs1_ok = run && addr_usable(rs1_addr);
  assign rs2_ok = run && addr_usable(rs2_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_idx   <= '0;
      init_done <= 1'b0;
      busy      <= '0;
    end else begin
      case (state)
        INIT: begin
          if (clr_idx == LAST_IDX) begin
            state     <= RUN;
            init_done <= 1'b1;
            clr_idx   <= '0;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        RUN: begin
          // Issue is applied after writeback so a same-address issue leaves the flag set.
          if (wr_ok)  busy[wr_addr] <= 1'b0;
          if (iss_ok) busy[iss_rd]  <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Array is deliberately unreset; the clear engine zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rs1_ok) begin
      rs1_data = mem[rs1_addr];
      rs1_busy = busy[rs1_addr];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
      rs1_busy = iss_ok && (iss_rd == rs1_addr);
    end
`endif
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs2_ok) begin
      rs2_data = mem[rs2_addr];
      rs2_busy = busy[rs2_addr];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
      rs2_busy = iss_ok && (iss_rd == rs2_addr);
    end
`endif
  end

endmodule
